// File: rtl/capture_pkg.sv
// Shared types for the acquisition controller: FSM states, buffer depth and address type.
package capture_pkg;

  localparam int CAP_ADDR_W = 9;
  localparam int CAP_DEC_W  = 4;
  localparam int DEPTH      = 2**CAP_ADDR_W;

  typedef logic [CAP_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl_smpl_decimator.sv
// Power-of-two sample pacing: strobe once every 2**decimator clocks while enabled.
module smpl_decimator #(
  parameter int DEC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DEC_W-1:0] decimator,
  output logic             strobe
);

  localparam int CNT_W = 2**DEC_W - 1;

  logic [CNT_W-1:0] dec_cnt_q;
  logic [CNT_W-1:0] dec_cnt_d;
  logic [CNT_W-1:0] target_s;

  // Terminal count and next counter value; the shift wraps so decimator=CNT_W still yields all ones.
  always_comb begin
    target_s  = (CNT_W'(1) << decimator) - CNT_W'(1);
    strobe    = en && (dec_cnt_q == target_s);
    dec_cnt_d = dec_cnt_q;
    if (!en || strobe) begin
      dec_cnt_d = '0;
    end else begin
      dec_cnt_d = dec_cnt_q + CNT_W'(1);
    end
  end

  // Interval counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition controller: paces sample-RAM writes, tracks pre/post-trigger counts and
// freezes the circular buffer once the post-trigger quota is written.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DEC_W  = CAP_DEC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic [DEC_W-1:0]  decimator,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              triggered,
  input  logic              capture_done_clr,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] last_addr
);

  localparam int DEPTH_C = 2**ADDR_W;
  localparam int SMPL_W  = ADDR_W + 1;

  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [SMPL_W-1:0] smpl_cnt_q, smpl_cnt_d;
  logic              we_q, we_d;
  logic              set_done_q, set_done_d;
  logic              done_q, done_d;
  logic              armed_q, armed_d;
  logic              dec_en_s;
  logic              strobe_s;
  logic [SMPL_W-1:0] smpl_sum_s;
  logic              arm_hit_s;

  assign dec_en_s = (state_q == CAPTURE);

  smpl_decimator #(.DEC_W(DEC_W)) u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (dec_en_s),
    .decimator (decimator),
    .strobe    (strobe_s)
  );

  // Next-state logic; wptr is the next slot to fill, waddr_q mirrors the slot written with we_q.
  always_comb begin
    smpl_sum_s  = smpl_cnt_q + SMPL_W'(trig_pos);
    arm_hit_s   = (smpl_sum_s >= SMPL_W'(DEPTH_C));
    state_d     = state_q;
    wptr_d      = wptr_q;
    waddr_d     = waddr_q;
    last_addr_d = last_addr_q;
    post_cnt_d  = post_cnt_q;
    smpl_cnt_d  = smpl_cnt_q;
    we_d        = 1'b0;
    set_done_d  = 1'b0;
    done_d      = done_q;
    armed_d     = armed_q;
    case (state_q)
      IDLE: begin
        armed_d = 1'b0;
        done_d  = 1'b0;
        if (capture_en) begin
          state_d    = CAPTURE;
          wptr_d     = '0;
          waddr_d    = '0;
          smpl_cnt_d = '0;
          post_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        armed_d = armed_q | arm_hit_s;
        if (!capture_en) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else if (strobe_s) begin
          if (triggered && (post_cnt_q == trig_pos)) begin
            state_d     = DONE;
            set_done_d  = 1'b1;
            done_d      = 1'b1;
            last_addr_d = wptr_q - ADDR_W'(1);
            armed_d     = 1'b0;
          end else begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wptr_d  = wptr_q + ADDR_W'(1);
            if (smpl_cnt_q != SMPL_W'(DEPTH_C)) begin
              smpl_cnt_d = smpl_cnt_q + SMPL_W'(1);
            end else begin
              smpl_cnt_d = smpl_cnt_q;
            end
            if (triggered) begin
              post_cnt_d = post_cnt_q + ADDR_W'(1);
            end else begin
              post_cnt_d = post_cnt_q;
            end
          end
        end else begin
          we_d = 1'b0;
        end
      end
      DONE: begin
        armed_d = 1'b0;
        if (capture_done_clr) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        armed_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      waddr_q     <= '0;
      last_addr_q <= '0;
      post_cnt_q  <= '0;
      smpl_cnt_q  <= '0;
      we_q        <= 1'b0;
      set_done_q  <= 1'b0;
      done_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      waddr_q     <= waddr_d;
      last_addr_q <= last_addr_d;
      post_cnt_q  <= post_cnt_d;
      smpl_cnt_q  <= smpl_cnt_d;
      we_q        <= we_d;
      set_done_q  <= set_done_d;
      done_q      <= done_d;
      armed_q     <= armed_d;
    end
  end

  assign armed            = armed_q;
  assign set_capture_done = set_done_q;
  assign capture_done     = done_q;
  assign we               = we_q;
  assign waddr            = waddr_q;
  assign last_addr        = last_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: predicted write addresses are queued when a capture
// is started and popped on every observed we pulse.
module tb_capture_ctrl;

  localparam int ADDR_W = 9;
  localparam int DEC_W  = 4;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              capture_en = 1'b0;
  logic [DEC_W-1:0]  decimator = '0;
  logic [ADDR_W-1:0] trig_pos = '0;
  logic              triggered = 1'b0;
  logic              capture_done_clr = 1'b0;
  logic              armed, set_capture_done, capture_done, we;
  logic [ADDR_W-1:0] waddr, last_addr;

  int errs = 0;
  int checks = 0;
  int exp_q[$];
  int cyc = 0;
  int n_we = 0;
  int n_set = 0;
  int arm_we = -1;
  int arm_drops = 0;
  int exp_gap = 0;
  int last_we_cyc = -1;
  logic armed_prev = 1'b0;

  capture_ctrl #(.ADDR_W(ADDR_W), .DEC_W(DEC_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .capture_en       (capture_en),
    .decimator        (decimator),
    .trig_pos         (trig_pos),
    .triggered        (triggered),
    .capture_done_clr (capture_done_clr),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .capture_done     (capture_done),
    .we               (we),
    .waddr            (waddr),
    .last_addr        (last_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge and score any write.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (set_capture_done) n_set++;
    if (armed && !armed_prev) arm_we = n_we;
    if (!armed && armed_prev && !set_capture_done) arm_drops++;
    if (we) begin
      n_we++;
      if (exp_q.size() == 0) chk("we_extra", exp_q.size(), 1);
      else chk("waddr", waddr, exp_q.pop_front());
      if (exp_gap != 0 && last_we_cyc >= 0) chk("we_gap", cyc - last_we_cyc, exp_gap);
      last_we_cyc = cyc;
    end
    armed_prev = armed;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_armed"}, armed, 0);
    chk({tag, "_set"}, set_capture_done, 0);
    chk({tag, "_done"}, capture_done, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_last"}, last_addr, 0);
  endtask

  // Start from IDLE, write pre samples, wait dly clocks, raise triggered and follow to DONE.
  task automatic run_trig(input int dec, input int tp, input int pre, input int dly, input string tag);
    int budget, w0, s0, exp_last;
    decimator = DEC_W'(dec);
    trig_pos = ADDR_W'(tp);
    exp_gap = 1 << dec;
    last_we_cyc = -1;
    n_we = 0;
    arm_we = -1;
    exp_last = (pre + tp - 1) % DEPTH;
    for (int i = 0; i < pre + tp; i++) exp_q.push_back(i % DEPTH);
    capture_en = 1'b1;
    budget = 0;
    while (n_we < pre && budget < 20000) begin step(); budget++; end
    chk({tag, "_pre"}, n_we, pre);
    repeat (dly) step();
    triggered = 1'b1;
    w0 = n_we;
    s0 = n_set;
    budget = 0;
    while (!set_capture_done && budget < 20000) begin step(); budget++; end
    chk({tag, "_post_writes"}, n_we - w0, tp);
    chk({tag, "_done_at_set"}, capture_done, 1);
    chk({tag, "_armed_at_set"}, armed, 0);
    chk({tag, "_last_addr"}, last_addr, exp_last);
    triggered = 1'b0;
    repeat (3) step();
    chk({tag, "_set_once"}, n_set - s0, 1);
    chk({tag, "_done_hold"}, capture_done, 1);
    chk({tag, "_we_in_done"}, we, 0);
    chk({tag, "_waddr_hold"}, waddr, exp_last);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic release_done(input logic en);
    capture_en = en;
    capture_done_clr = 1'b1;
    step();
    capture_done_clr = 1'b0;
    chk("clr_done", capture_done, 0);
    chk("clr_we", we, 0);
  endtask

  initial begin
    int budget, s0, d0;
    // Reset state
    repeat (3) step();
    check_all_zero("rst");
    rst_n = 1'b1;
    step();
    check_all_zero("post_rst");

    // Decimation by 4 and address wrap, no trigger
    decimator = DEC_W'(2);
    trig_pos = '0;
    exp_gap = 4;
    last_we_cyc = -1;
    n_we = 0;
    for (int i = 0; i <= DEPTH; i++) exp_q.push_back(i % DEPTH);
    capture_en = 1'b1;
    budget = 0;
    while (n_we < DEPTH + 1 && budget < 3000) begin step(); budget++; end
    chk("wrap_writes", n_we, DEPTH + 1);
    chk("wrap_sb_empty", exp_q.size(), 0);
    s0 = n_set;
    capture_en = 1'b0;
    step();
    chk("abort1_we", we, 0);
    chk("abort1_armed", armed, 0);
    chk("abort1_done", capture_done, 0);
    repeat (6) step();
    chk("abort1_no_set", n_set - s0, 0);

    // Arming and a normal capture with trig_pos=100
    d0 = arm_drops;
    run_trig(0, 100, 433, 0, "norm");
    chk("arm_at", arm_we, DEPTH - 100);
    chk("arm_no_drop", arm_drops - d0, 0);

    // Handshake with capture_en held: one IDLE clock, then restart at address 0, then abort
    exp_gap = 1;
    last_we_cyc = -1;
    n_we = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(i);
    s0 = n_set;
    release_done(1'b1);
    step();
    chk("idle_gap_we", we, 0);
    step();
    chk("restart_we", we, 1);
    budget = 0;
    while (n_we < 10 && budget < 100) begin step(); budget++; end
    capture_en = 1'b0;
    step();
    chk("abort2_we", we, 0);
    chk("abort2_done", capture_done, 0);
    chk("abort2_armed", armed, 0);
    repeat (3) step();
    chk("abort2_we_idle", we, 0);
    chk("abort2_no_set", n_set - s0, 0);
    chk("abort2_sb_empty", exp_q.size(), 0);

    // trig_pos=0: done on the first strobe seeing triggered, no further writes
    run_trig(1, 0, 5, 0, "tp0");
    release_done(1'b0);

    // triggered rises just before a strobe edge: that strobe counts as the first post sample
    run_trig(1, 3, 5, 1, "same");
    release_done(1'b0);

    // Asynchronous reset mid-capture with we active
    decimator = '0;
    exp_gap = 1;
    last_we_cyc = -1;
    n_we = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(i);
    capture_en = 1'b1;
    budget = 0;
    while (n_we < 3 && budget < 100) begin step(); budget++; end
    chk("pre_rst_we", we, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    capture_en = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_idle_we", we, 0);
    capture_en = 1'b1;
    last_we_cyc = -1;
    exp_q.push_back(0);
    step();
    chk("rst_restart_gap", we, 0);
    step();
    chk("rst_restart_we", we, 1);
    capture_en = 1'b0;
    step();
    chk("rst_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Acquisition controller downstream of the trigger detector. Paces sample-RAM writes through a power-of-two decimator and keeps a circular write pointer.
- Asserts armed once enough pre-trigger samples are held. After triggered, counts trig_pos post-trigger samples, then pulses set_capture_done, which clears the trigger latch, and freezes the buffer for readout.

Parameters:
- ADDR_W, 9, sample-RAM address width; DEPTH = 2**ADDR_W entries (512).
- DEC_W, 4, width of decimator select; the sample interval is 2**decimator clocks.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- capture_en  input  1  level; high starts/continues acquisition, low aborts
- decimator  input  DEC_W  sample strobe every 2**decimator clocks (0 = every clock)
- trig_pos  input  ADDR_W  number of samples to write after the trigger
- triggered  input  1  level from trigger detector, held until set_capture_done
- capture_done_clr  input  1  host acknowledge; one-clock pulse releases DONE
- armed  output  1  enough pre-trigger history held; gates the trigger detector
- set_capture_done  output  1  one-clock pulse at end of capture
- capture_done  output  1  status level, high while in DONE
- we  output  1  sample-RAM write enable, one clock per strobe
- waddr  output  ADDR_W  sample-RAM write address
- last_addr  output  ADDR_W  address of final sample written (readout start = last_addr+1)

Behaviour:
- Reset: state IDLE. All counters 0. armed, set_capture_done, capture_done, we, waddr and last_addr all 0.
- States: IDLE, CAPTURE, DONE. All outputs are registered.
- IDLE:
  - When capture_en=1, clear dec_cnt, smpl_cnt, post_cnt and waddr, then go to CAPTURE the next cycle.
  - we=0 and armed=0.
- Decimation:
  - dec_cnt is 2**DEC_W-1 bits wide and runs only in CAPTURE.
  - strobe = (dec_cnt == 2**decimator - 1); dec_cnt resets to 0 on strobe, otherwise increments.
  - decimator=0 gives a strobe every clock.
  - decimator is sampled live; changing it mid-capture is legal but not glitch-protected.
- CAPTURE, on a strobe:
  - If triggered=1 and post_cnt==trig_pos: go to DONE and write nothing. Pulse set_capture_done for exactly one clock. Load last_addr = waddr-1 (mod DEPTH). Clear armed.
  - Otherwise: we=1 for one clock at the current waddr, then waddr increments and wraps from DEPTH-1 to 0.
  - smpl_cnt increments and saturates at DEPTH.
  - If triggered=1, post_cnt also increments.
- CAPTURE, with no strobe: we=0.
- armed: registered. It rises the clock after smpl_cnt + trig_pos >= DEPTH, computed at ADDR_W+1 bits with no overflow, and stays high until CAPTURE is left.
- triggered is ignored outside CAPTURE, and inside CAPTURE until the first strobe after it rises.
- trig_pos=0: done on the first strobe that sees triggered=1, with zero post-trigger samples.
- capture_en=0 in CAPTURE: abort to IDLE the next clock. No set_capture_done pulse, capture_done stays 0, armed=0.
- DONE:
  - capture_done=1, we=0, waddr held.
  - capture_done_clr=1 moves to IDLE.
  - capture_en is ignored while in DONE.
  - If capture_done_clr and capture_en are both high, spend one clock in IDLE and then restart.
- Asynchronous reset mid-capture returns every output to its reset value immediately.

Decomposition:
- Package capture_pkg holds:
  - typedef enum logic [1:0] {IDLE, CAPTURE, DONE} cap_state_t;
  - localparam DEPTH;
  - typedef for the address type.
- One sub-module, smpl_decimator, contains dec_cnt and generates strobe from decimator, clk, rst_n and an enable input.
- The FSM, the address/sample/post counters and the armed compare live in capture_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-CAPTURE with we active -> every output is 0 the same cycle, and state is IDLE after release.
- Decimation and address wrap: decimator=2, capture_en=1, no trigger -> we pulses every 4 clocks; waddr runs 0,1,...,511, then 0.
- Arming: decimator=0, trig_pos=100 -> armed rises one clock after the 412th write, i.e. smpl_cnt=412, and stays high.
- Normal capture: trig_pos=100 with triggered raised after arming -> exactly 100 writes follow the first strobe that sees triggered. set_capture_done pulses once; capture_done=1; last_addr equals the address of the 100th post-trigger write.
- Edge cases:
  - trig_pos=0 -> set_capture_done on the first strobe after triggered, with zero writes after it.
  - triggered and the strobe on the same clock -> the trigger is counted on that strobe.
- Abort and handshake:
  - Drop capture_en mid-CAPTURE -> IDLE the next clock, no set_capture_done.
  - In DONE, pulse capture_done_clr with capture_en=1 -> one IDLE clock, then a new capture with waddr reset to 0.
